updown_sweep_ctrl: RTL and testbench

Sequencing controller for the team's up/down counter datapath. It latches a programmable window (lo..hi), a count mode and a sweep budget, then steps the embedded counter through up-wrap, down-wrap or bounce sweeps. It stops automatically after N sweeps, or runs forever when N = 0. It sits between a host or config register block and any logic consuming the count value and direction.

---
 rtl/updown_sweep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for the up/down counter: latches a lo..hi window, mode and sweep budget, then runs wrap or bounce sweeps.
// Defining UDC_TC_PULSE_EN adds a tc output that pulses on every boundary event and bounce turnaround.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [1:0]         cfg_mode,
    input  logic [SWEEP_W-1:0] cfg_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
`ifdef UDC_TC_PULSE_EN
    ,
    output logic               tc
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    stateT              state;
    logic [WIDTH-1:0]   loReg;
    logic [WIDTH-1:0]   hiReg;
    logic [1:0]         modeReg;
    logic [SWEEP_W-1:0] sweepsReg;

    logic [WIDTH-1:0]   stepCount;
    logic               stepDir;
    logic               boundary;
    logic [SWEEP_W-1:0] sweepNext;
    logic               finalEvent;

    // Next count/dir for one unpaused RUN cycle; bounds are tested before moving so the count never leaves the window.
    always_comb begin
        stepCount = count;
        stepDir   = dir;
        boundary  = 1'b0;
        case (modeReg)
            MODE_UP: begin
                if (count == hiReg) begin
                    boundary  = 1'b1;
                    stepCount = loReg;
                end else begin
                    stepCount = count + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (count == loReg) begin
                    boundary  = 1'b1;
                    stepCount = hiReg;
                end else begin
                    stepCount = count - WIDTH'(1);
                end
            end
            default: begin
                if (loReg == hiReg) begin
                    boundary  = 1'b1;
                    stepCount = loReg;
                end else if (dir) begin
                    if (count == hiReg) begin
                        stepDir   = 1'b0;
                        stepCount = hiReg - WIDTH'(1);
                    end else begin
                        stepCount = count + WIDTH'(1);
                    end
                end else begin
                    if (count == loReg) begin
                        boundary  = 1'b1;
                        stepDir   = 1'b1;
                        stepCount = loReg + WIDTH'(1);
                    end else begin
                        stepCount = count - WIDTH'(1);
                    end
                end
            end
        endcase
    end

    assign sweepNext  = (&sweep_cnt) ? sweep_cnt : sweep_cnt + SWEEP_W'(1);
    assign finalEvent = boundary && (sweepsReg != '0) && (sweepNext == sweepsReg);

    // Control FSM; the budget-ending event freezes count/dir at the terminal value instead of wrapping or turning.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            dir       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_cnt <= '0;
            loReg     <= '0;
            hiReg     <= '0;
            modeReg   <= MODE_UP;
            sweepsReg <= '0;
`ifdef UDC_TC_PULSE_EN
            tc        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef UDC_TC_PULSE_EN
            tc   <= 1'b0;
`endif
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            loReg     <= cfg_lo;
                            hiReg     <= cfg_hi;
                            modeReg   <= cfg_mode;
                            sweepsReg <= cfg_sweeps;
                            if ((cfg_lo > cfg_hi) || (cfg_mode == MODE_RSVD)) begin
                                err <= 1'b1;
                            end else begin
                                count     <= (cfg_mode == MODE_DOWN) ? cfg_hi : cfg_lo;
                                dir       <= (cfg_mode != MODE_DOWN);
                                sweep_cnt <= '0;
                                busy      <= 1'b1;
                                state     <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (!pause) begin
                            if (boundary) begin
                                sweep_cnt <= sweepNext;
                            end
`ifdef UDC_TC_PULSE_EN
                            tc <= boundary || (stepDir != dir);
`endif
                            if (finalEvent) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                count <= stepCount;
                                dir   <= stepDir;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: expected sequences are built as whole sweep patterns and walked cycle by cycle.
// Works with or without UDC_TC_PULSE_EN; tc is checked only when the macro is defined.
module tb_updown_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] cfg_lo;
    logic [3:0] cfg_hi;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_sweeps;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] sweep_cnt;
`ifdef UDC_TC_PULSE_EN
    logic       tc;
`endif

    typedef struct {
        logic [3:0] c;
        logic       d;
        logic [7:0] s;
        logic       t;
    } stepT;

    stepT       trace[$];
    int         nAsserts = 0;
    int         nFail    = 0;
    logic [3:0] expCount;
    logic       expDir;
    logic [7:0] expSweep;

    updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_mode   (cfg_mode),
        .cfg_sweeps (cfg_sweeps),
        .count      (count),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_cnt  (sweep_cnt)
`ifdef UDC_TC_PULSE_EN
        ,
        .tc         (tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of control inputs and sample just after the following rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic ps);
        start = s;
        stop  = p;
        pause = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eCount, input logic eDir,
                               input logic eBusy, input logic eDone, input logic eErr,
                               input logic [7:0] eSweep, input logic eTc);
        nAsserts++;
        assert (count === eCount) else begin
            nFail++;
            $error("[TB] FAIL %s.count observed %0d expected %0d", tag, count, eCount);
        end
        nAsserts++;
        assert (dir === eDir) else begin
            nFail++;
            $error("[TB] FAIL %s.dir observed %b expected %b", tag, dir, eDir);
        end
        nAsserts++;
        assert (busy === eBusy) else begin
            nFail++;
            $error("[TB] FAIL %s.busy observed %b expected %b", tag, busy, eBusy);
        end
        nAsserts++;
        assert (done === eDone) else begin
            nFail++;
            $error("[TB] FAIL %s.done observed %b expected %b", tag, done, eDone);
        end
        nAsserts++;
        assert (err === eErr) else begin
            nFail++;
            $error("[TB] FAIL %s.err observed %b expected %b", tag, err, eErr);
        end
        nAsserts++;
        assert (sweep_cnt === eSweep) else begin
            nFail++;
            $error("[TB] FAIL %s.sweep_cnt observed %0d expected %0d", tag, sweep_cnt, eSweep);
        end
`ifdef UDC_TC_PULSE_EN
        nAsserts++;
        assert (tc === eTc) else begin
            nFail++;
            $error("[TB] FAIL %s.tc observed %b expected %b", tag, tc, eTc);
        end
`else
        if (eTc === 1'bx) $display("[TB] %s: undefined tc expectation", tag);
`endif
    endtask

    function automatic void pushStep(int v, logic d, int k, logic t);
        stepT e;
        e.c = 4'(v);
        e.d = d;
        e.s = (k > 255) ? 8'd255 : 8'(k);
        e.t = t;
        trace.push_back(e);
    endfunction

    // One entry per busy cycle: sweep k contributes its whole pattern, tagged with k as the visible sweep count.
    function automatic void buildTrace(int lo, int hi, int mode, int nSweeps);
        trace.delete();
        for (int k = 0; k < nSweeps; k++) begin
            if (mode == 0) begin
                for (int v = lo; v <= hi; v++) pushStep(v, 1'b1, k, (v == lo) && (k > 0));
            end else if (mode == 1) begin
                for (int v = hi; v >= lo; v--) pushStep(v, 1'b0, k, (v == hi) && (k > 0));
            end else if (lo == hi) begin
                pushStep(lo, 1'b1, k, k > 0);
            end else begin
                for (int v = (k == 0) ? lo : lo + 1; v <= hi; v++)
                    pushStep(v, 1'b1, k, (v == lo + 1) && (k > 0));
                for (int v = hi - 1; v >= lo; v--)
                    pushStep(v, 1'b0, k, v == hi - 1);
            end
        end
    endfunction

    task automatic runCase(input string tag, input int lo, input int hi, input int mode,
                           input int sweeps, input int maxSteps, input bit noisy);
        int   idx    = 0;
        int   steps  = 0;
        logic paused = 1'b0;
        logic pNext;
        logic sNext;
        stepT last;
        buildTrace(lo, hi, mode, (sweeps != 0) ? sweeps : maxSteps + 2);
        cfg_lo     = 4'(lo);
        cfg_hi     = 4'(hi);
        cfg_mode   = 2'(mode);
        cfg_sweeps = 8'(sweeps);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            checkOutput(tag, trace[idx].c, trace[idx].d, 1'b1, 1'b0, 1'b0, trace[idx].s,
                        paused ? 1'b0 : trace[idx].t);
            if (sweeps == 0 && steps == maxSteps) break;
            pNext = noisy && ($urandom_range(0, 3) == 0);
            sNext = noisy && ($urandom_range(0, 5) == 0);
            applyStimulus(sNext, 1'b0, pNext);
            paused = pNext;
            if (!pNext) begin
                idx++;
                steps++;
            end
            if (idx == trace.size()) break;
        end
        if (sweeps != 0) begin
            last = trace[trace.size() - 1];
            checkOutput({tag, "-done"}, last.c, last.d, 1'b0, 1'b1, 1'b0, 8'(sweeps), 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput({tag, "-idle"}, last.c, last.d, 1'b0, 1'b0, 1'b0, 8'(sweeps), 1'b0);
        end else begin
            last = trace[idx];
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput({tag, "-stop"}, last.c, last.d, 1'b0, 1'b0, 1'b0, last.s, 1'b0);
        end
        expCount = last.c;
        expDir   = last.d;
        expSweep = (sweeps != 0) ? 8'(sweeps) : last.s;
    endtask

    task automatic errCase(input string tag, input int lo, input int hi, input int mode);
        cfg_lo     = 4'(lo);
        cfg_hi     = 4'(hi);
        cfg_mode   = 2'(mode);
        cfg_sweeps = 8'($urandom_range(0, 3));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput(tag, expCount, expDir, 1'b0, 1'b0, 1'b1, expSweep, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "-after"}, expCount, expDir, 1'b0, 1'b0, 1'b0, expSweep, 1'b0);
    endtask

    initial begin
        int lo;
        int hi;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        cfg_lo     = '0;
        cfg_hi     = '0;
        cfg_mode   = '0;
        cfg_sweeps = '0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        rst      = 1'b0;
        expCount = 4'd0;
        expDir   = 1'b1;
        expSweep = 8'd0;

        runCase("bounce-full", 0, 15, 2, 1, 0, 1'b0);
        runCase("upwrap", 3, 6, 0, 2, 0, 1'b0);
        errCase("err-order", 9, 4, 0);
        errCase("err-mode", 2, 8, 3);
        runCase("downwrap-flat", 5, 5, 1, 3, 0, 1'b0);

        // Pause at 7, then start and stop together: stop must win and nothing else may move.
        cfg_lo     = 4'd0;
        cfg_hi     = 4'd15;
        cfg_mode   = 2'd2;
        cfg_sweeps = 8'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 7; i++) begin
            checkOutput("pause-run", 4'(i), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            if (i < 7) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("pause-hold", 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("start-stop", 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stop-idle", 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Reset in the middle of a run.
        cfg_lo   = 4'd2;
        cfg_hi   = 4'd9;
        cfg_mode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst-run1", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst-run2", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        rst      = 1'b0;
        expCount = 4'd0;
        expDir   = 1'b1;
        expSweep = 8'd0;

        for (int r = 0; r < 8; r++) begin
            lo = int'($urandom_range(0, 15));
            hi = int'($urandom_range(lo, 15));
            runCase("rand", lo, hi, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 0, 1'b1);
        end
        lo = int'($urandom_range(1, 15));
        hi = int'($urandom_range(0, lo - 1));
        errCase("err-rand", lo, hi, int'($urandom_range(0, 3)));
        runCase("rand-endless", 1, 12, int'($urandom_range(0, 2)), 0, 40, 1'b1);

        lo = int'($urandom_range(0, 15));
        runCase("saturate", lo, lo, 0, 0, 300, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
